// File: rtl/dvp_frame_capture.sv
// DVP sensor capture front-end: assembles pixels from the 8-bit bus and applies frame decimation and a crop window.
// It also produces pixel coordinates, frame/line markers and sticky sensor timing error flags in the pclk domain.
module dvp_frame_capture #(
    parameter int unsigned MAX_WIDTH         = 1024,
    parameter int unsigned MAX_HEIGHT        = 1024,
    parameter int unsigned BYTES_PER_PIXEL   = 2,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit          HREF_ACTIVE_HIGH  = 1'b1,
    localparam int unsigned XW = $clog2(MAX_WIDTH),
    localparam int unsigned YW = $clog2(MAX_HEIGHT),
    localparam int unsigned PW = 8 * BYTES_PER_PIXEL
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    data,
    input  logic          enable,
    input  logic [3:0]    cfg_decim,
    input  logic [XW-1:0] cfg_width,
    input  logic [YW-1:0] cfg_height,
    input  logic [XW-1:0] cfg_x0,
    input  logic [XW-1:0] cfg_w,
    input  logic [YW-1:0] cfg_y0,
    input  logic [YW-1:0] cfg_h,
    output logic [PW-1:0] pix_data,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          frame_done,
    output logic          err_line,
    output logic          err_partial,
    output logic          err_frame,
    output logic          busy
);
    localparam int unsigned   BW        = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_PIXEL - 1);
    localparam logic [XW-1:0] COL_MAX   = XW'(MAX_WIDTH - 1);
    localparam logic [YW-1:0] LINE_MAX  = YW'(MAX_HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        LINE_WAIT,
        LINE,
        LINE_END,
        FRAME_END
    } state_t;

    state_t        state_q, state_d;
    logic          vs_pend_q, vs_pend_d;
    logic          byte_c, line_end_c, frame_end_c, cap_start_c, abort_c;

    logic          vs_q, hr_q, vs_act_d;
    logic [7:0]    data_q;
    logic [1:0]    arm_q;
    logic          vs_act, hr_act, vs_start, vs_end;

    logic [3:0]    decim_q;
    logic [XW-1:0] sh_width_q, sh_x0_q, sh_w_q;
    logic [YW-1:0] sh_height_q, sh_y0_q, sh_h_q;
    logic [XW-1:0] col_q;
    logic [YW-1:0] line_q;
    logic [BW-1:0] byte_idx_q;
    logic [PW-1:0] acc_q, acc_shift_c;

    logic          s1_valid_q;
    logic [PW-1:0] s1_data_q;
    logic [XW-1:0] s1_col_q;
    logic [YW-1:0] s1_line_q;

    logic [XW:0]   x_end_c;
    logic [YW:0]   y_end_c;
    logic [XW-1:0] rel_x_c;
    logic [YW-1:0] rel_y_c;
    logic          in_win_c, emit_c, sof_c, eol_c;

    // Input register; edge detection is held off until two real samples are in, so a reset mid-frame cannot fake a vs_start
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            hr_q     <= !HREF_ACTIVE_HIGH;
            data_q   <= '0;
            vs_act_d <= 1'b0;
            arm_q    <= '0;
        end else begin
            vs_q     <= vsync;
            hr_q     <= href;
            data_q   <= data;
            vs_act_d <= vs_act;
            arm_q    <= {arm_q[0], 1'b1};
        end
    end

    assign vs_act   = VSYNC_ACTIVE_HIGH ? vs_q : !vs_q;
    assign hr_act   = HREF_ACTIVE_HIGH ? hr_q : !hr_q;
    assign vs_start = arm_q[1] && vs_act_d && !vs_act;
    assign vs_end   = arm_q[1] && !vs_act_d && vs_act;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vs_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_pend_q <= vs_pend_d;
        end
    end

    // Next state; a vs_start overrides everything and re-evaluates as from IDLE
    always_comb begin
        state_d     = state_q;
        vs_pend_d   = 1'b0;
        byte_c      = 1'b0;
        line_end_c  = 1'b0;
        frame_end_c = 1'b0;
        cap_start_c = 1'b0;
        abort_c     = 1'b0;
        case (state_q)
            IDLE:      state_d = IDLE;
            SKIP:      if (vs_end) state_d = IDLE;
            LINE_WAIT: begin
                if (vs_end) begin
                    state_d = FRAME_END;
                end else if (hr_act) begin
                    state_d = LINE;
                    byte_c  = 1'b1;
                end
            end
            LINE: begin
                if (!hr_act || vs_end) begin
                    state_d   = LINE_END;
                    vs_pend_d = vs_end;
                end else begin
                    byte_c = 1'b1;
                end
            end
            LINE_END: begin
                line_end_c = 1'b1;
                state_d    = (vs_pend_q || vs_end) ? FRAME_END : LINE_WAIT;
            end
            FRAME_END: begin
                frame_end_c = 1'b1;
                state_d     = IDLE;
            end
            default:   state_d = IDLE;
        endcase
        if (vs_start) begin
            abort_c     = (state_q != IDLE);
            byte_c      = 1'b0;
            line_end_c  = 1'b0;
            frame_end_c = 1'b0;
            vs_pend_d   = 1'b0;
            if (enable) begin
                cap_start_c = (decim_q == '0);
                state_d     = cap_start_c ? LINE_WAIT : SKIP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign acc_shift_c = PW'({acc_q, data_q});

    // Shadow config, decimation, counters and byte assembly into the first pipeline stage
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q     <= '0;
            sh_width_q  <= '0;
            sh_height_q <= '0;
            sh_x0_q     <= '0;
            sh_w_q      <= '0;
            sh_y0_q     <= '0;
            sh_h_q      <= '0;
            col_q       <= '0;
            line_q      <= '0;
            byte_idx_q  <= '0;
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_col_q    <= '0;
            s1_line_q   <= '0;
        end else begin
            s1_valid_q <= 1'b0;
            if (vs_start) begin
                decim_q     <= (decim_q >= cfg_decim) ? 4'd0 : decim_q + 4'd1;
                sh_width_q  <= cfg_width;
                sh_height_q <= cfg_height;
                sh_x0_q     <= cfg_x0;
                sh_w_q      <= cfg_w;
                sh_y0_q     <= cfg_y0;
                sh_h_q      <= cfg_h;
                col_q       <= '0;
                line_q      <= '0;
                byte_idx_q  <= '0;
            end else if (line_end_c) begin
                col_q      <= '0;
                byte_idx_q <= '0;
                if (line_q != LINE_MAX) line_q <= line_q + YW'(1);
            end else if (byte_c) begin
                acc_q <= acc_shift_c;
                if (byte_idx_q == LAST_BYTE) begin
                    byte_idx_q <= '0;
                    s1_valid_q <= 1'b1;
                    s1_data_q  <= acc_shift_c;
                    s1_col_q   <= col_q;
                    s1_line_q  <= line_q;
                    if (col_q != COL_MAX) col_q <= col_q + XW'(1);
                end else begin
                    byte_idx_q <= byte_idx_q + BW'(1);
                end
            end
        end
    end

    // Crop window test; a zero width/height disables cropping on that axis
    always_comb begin
        x_end_c  = {1'b0, sh_x0_q} + {1'b0, sh_w_q};
        y_end_c  = {1'b0, sh_y0_q} + {1'b0, sh_h_q};
        rel_x_c  = (sh_w_q == '0) ? s1_col_q  : s1_col_q - sh_x0_q;
        rel_y_c  = (sh_h_q == '0) ? s1_line_q : s1_line_q - sh_y0_q;
        in_win_c = ((sh_w_q == '0) || ((s1_col_q >= sh_x0_q) && ({1'b0, s1_col_q} < x_end_c)))
                && ((sh_h_q == '0) || ((s1_line_q >= sh_y0_q) && ({1'b0, s1_line_q} < y_end_c)));
        emit_c   = s1_valid_q && in_win_c;
        sof_c    = (rel_x_c == '0) && (rel_y_c == '0);
        eol_c    = ((sh_w_q != '0) && (rel_x_c == sh_w_q - XW'(1))) || !hr_act;
    end

    // Output stage and sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_partial <= 1'b0;
            err_frame   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pix_valid  <= emit_c;
            pix_sof    <= emit_c && sof_c;
            pix_eol    <= emit_c && eol_c;
            frame_done <= frame_end_c;
            busy       <= (state_d != IDLE);
            if (emit_c) begin
                pix_data <= s1_data_q;
                pix_x    <= rel_x_c;
                pix_y    <= rel_y_c;
            end
            if (cap_start_c) begin
                err_line    <= 1'b0;
                err_partial <= 1'b0;
                err_frame   <= 1'b0;
            end
            if (line_end_c && (byte_idx_q != '0)) err_partial <= 1'b1;
            if (line_end_c && (col_q != sh_width_q)) err_line <= 1'b1;
            if ((frame_end_c && (line_q != sh_height_q)) || abort_c) err_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Directed bench for dvp_frame_capture: an active-high and an active-low vsync instance share stimulus.
// Expected pixels are queued when frames are driven and are popped as the DUT emits them.
module tb_dvp_frame_capture;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 10;
    localparam int unsigned PW = 16;

    logic          pclk = 1'b0;
    logic          rst_n, vsync, vsync_n, href, enable;
    logic [7:0]    data;
    logic [3:0]    cfg_decim;
    logic [XW-1:0] cfg_width, cfg_x0, cfg_w;
    logic [YW-1:0] cfg_height, cfg_y0, cfg_h;

    logic [PW-1:0] pix_data   [2];
    logic [XW-1:0] pix_x      [2];
    logic [YW-1:0] pix_y      [2];
    logic          pix_valid  [2];
    logic          pix_sof    [2];
    logic          pix_eol    [2];
    logic          frame_done [2];
    logic          err_line   [2];
    logic          err_partial[2];
    logic          err_frame  [2];
    logic          busy       [2];

    logic [63:0]   q0[$];
    logic [63:0]   q1[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    int            fd_cnt  [2] = '{0, 0};
    int            fd_snap [2] = '{0, 0};

    always #5 pclk = ~pclk;
    assign vsync_n = ~vsync;

    dvp_frame_capture u_dut_hi (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .data(data), .enable(enable),
        .cfg_decim(cfg_decim), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_x0(cfg_x0), .cfg_w(cfg_w), .cfg_y0(cfg_y0), .cfg_h(cfg_h),
        .pix_data(pix_data[0]), .pix_valid(pix_valid[0]), .pix_x(pix_x[0]), .pix_y(pix_y[0]),
        .pix_sof(pix_sof[0]), .pix_eol(pix_eol[0]), .frame_done(frame_done[0]),
        .err_line(err_line[0]), .err_partial(err_partial[0]), .err_frame(err_frame[0]), .busy(busy[0])
    );

    dvp_frame_capture #(.VSYNC_ACTIVE_HIGH(1'b0)) u_dut_lo (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync_n), .href(href), .data(data), .enable(enable),
        .cfg_decim(cfg_decim), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_x0(cfg_x0), .cfg_w(cfg_w), .cfg_y0(cfg_y0), .cfg_h(cfg_h),
        .pix_data(pix_data[1]), .pix_valid(pix_valid[1]), .pix_x(pix_x[1]), .pix_y(pix_y[1]),
        .pix_sof(pix_sof[1]), .pix_eol(pix_eol[1]), .frame_done(frame_done[1]),
        .err_line(err_line[1]), .err_partial(err_partial[1]), .err_frame(err_frame[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] d, input logic [9:0] x, input logic [9:0] y,
                                       input logic s, input logic e);
        return {26'b0, s, e, y, x, d};
    endfunction

    function automatic logic [63:0] outs(input int i);
        return {20'b0, pix_data[i], pix_valid[i], pix_x[i], pix_y[i], pix_sof[i], pix_eol[i],
                frame_done[i], err_line[i], err_partial[i], err_frame[i], busy[i]};
    endfunction

    function automatic logic [7:0] byte_of(input int base, input int nbytes, input int l, input int k);
        return 8'(base + l * nbytes + k);
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge pclk) begin
        logic [63:0] e;
        logic        have;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (frame_done[i]) fd_cnt[i]++;
                if (pix_valid[i]) begin
                    e    = '0;
                    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (have) e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (!have)
                        check($sformatf("pix_unexpected_dut%0d", i), 64'(pix_valid[i]), 64'(0));
                    else
                        check($sformatf("pix_dut%0d", i),
                              pk(pix_data[i], pix_x[i], pix_y[i], pix_sof[i], pix_eol[i]), e);
                end
            end
        end
    end

    task automatic set_cfg(input int decim, input int w_cfg, input int h_cfg,
                           input int x0, input int w, input int y0, input int h);
        cfg_decim  = 4'(decim);
        cfg_width  = XW'(w_cfg);
        cfg_height = YW'(h_cfg);
        cfg_x0     = XW'(x0);
        cfg_w      = XW'(w);
        cfg_y0     = YW'(y0);
        cfg_h      = YW'(h);
    endtask

    // Reference crop model for a frame of 2-byte pixels; only lines below 'upto' are captured
    task automatic expect_frame(input int nlines, input int nbytes, input int base,
                                input int x0, input int w, input int y0, input int h, input int upto);
        int npix;
        npix = nbytes / 2;
        for (int l = 0; l < upto && l < nlines; l++) begin
            for (int x = 0; x < npix; x++) begin
                bit in_x, in_y, sof, eol;
                int rx, ry;
                in_x = (w == 0) || (x >= x0 && x < x0 + w);
                in_y = (h == 0) || (l >= y0 && l < y0 + h);
                rx   = (w == 0) ? x : x - x0;
                ry   = (h == 0) ? l : l - y0;
                if (in_x && in_y) begin
                    sof = (rx == 0) && (ry == 0);
                    eol = (w != 0 && rx == w - 1) || (x == npix - 1 && nbytes % 2 == 0);
                    q0.push_back(pk({byte_of(base, nbytes, l, 2 * x), byte_of(base, nbytes, l, 2 * x + 1)},
                                    10'(rx), 10'(ry), sof, eol));
                    q1.push_back(pk({byte_of(base, nbytes, l, 2 * x), byte_of(base, nbytes, l, 2 * x + 1)},
                                    10'(rx), 10'(ry), sof, eol));
                end
            end
        end
    endtask

    // One sensor frame; a reset is pulsed after the first byte of line rst_line
    task automatic drive_frame(input int nlines, input int nbytes, input int base, input int rst_line);
        vsync = 1'b0;
        repeat (4) @(negedge pclk);
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) begin
                @(negedge pclk);
                href = 1'b1;
                data = byte_of(base, nbytes, l, 0);
                @(negedge pclk);
                rst_n = 1'b0;
                repeat (2) @(negedge pclk);
                for (int i = 0; i < 2; i++)
                    check($sformatf("rst_outputs_dut%0d", i), outs(i), 64'(0));
                rst_n = 1'b1;
                href  = 1'b0;
                repeat (3) @(negedge pclk);
                continue;
            end
            for (int k = 0; k < nbytes; k++) begin
                @(negedge pclk);
                href = 1'b1;
                data = byte_of(base, nbytes, l, k);
            end
            @(negedge pclk);
            href = 1'b0;
            repeat (3) @(negedge pclk);
        end
        vsync = 1'b1;
        repeat (6) @(negedge pclk);
    endtask

    task automatic snap();
        fd_snap[0] = fd_cnt[0];
        fd_snap[1] = fd_cnt[1];
    endtask

    task automatic end_test(input string tag, input int done, input logic el, input logic ep, input logic ef);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_frame_done_dut%0d", tag, i), 64'(fd_cnt[i] - fd_snap[i]), 64'(done));
            check($sformatf("%s_errs_busy_dut%0d", tag, i),
                  64'({err_line[i], err_partial[i], err_frame[i], busy[i]}), 64'({el, ep, ef, 1'b0}));
        end
        check($sformatf("%s_queue_dut0", tag), 64'(q0.size()), 64'(0));
        check($sformatf("%s_queue_dut1", tag), 64'(q1.size()), 64'(0));
    endtask

    initial begin
        rst_n  = 1'b0;
        vsync  = 1'b1;
        href   = 1'b0;
        data   = 8'h00;
        enable = 1'b1;
        set_cfg(0, 4, 3, 0, 0, 0, 0);
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs_dut%0d", i), outs(i), 64'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge pclk);

        // Basic 4x3 frame, bytes 0x01..0x18
        snap();
        expect_frame(3, 8, 1, 0, 0, 0, 0, 3);
        drive_frame(3, 8, 1, -1);
        end_test("basic", 1, 1'b0, 1'b0, 1'b0);

        // Decimation by 3: frames 0 and 3 of six
        set_cfg(2, 4, 3, 0, 0, 0, 0);
        snap();
        for (int f = 0; f < 6; f++) begin
            if (f % 3 == 0) expect_frame(3, 8, 8'h30 + f, 0, 0, 0, 0, 3);
            drive_frame(3, 8, 8'h30 + f, -1);
        end
        end_test("decim", 2, 1'b0, 1'b0, 1'b0);

        // 8x8 frame cropped to 3x2 at (2,5)
        set_cfg(0, 8, 8, 2, 3, 5, 2);
        snap();
        expect_frame(8, 16, 8'h20, 2, 3, 5, 2, 8);
        drive_frame(8, 16, 8'h20, -1);
        end_test("crop", 1, 1'b0, 1'b0, 1'b0);

        // Five-byte line: partial pixel and short line, flags sticky until next capture
        set_cfg(0, 3, 1, 0, 0, 0, 0);
        snap();
        expect_frame(1, 5, 8'h40, 0, 0, 0, 0, 1);
        drive_frame(1, 5, 8'h40, -1);
        end_test("partial", 1, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge pclk);
        end_test("partial_hold", 1, 1'b1, 1'b1, 1'b0);
        set_cfg(0, 4, 2, 0, 0, 0, 0);
        snap();
        expect_frame(2, 8, 8'h50, 0, 0, 0, 0, 2);
        drive_frame(2, 8, 8'h50, -1);
        end_test("partial_clear", 1, 1'b0, 1'b0, 1'b0);

        // Two lines against an expected height of three
        set_cfg(0, 4, 3, 0, 0, 0, 0);
        snap();
        expect_frame(2, 8, 8'h60, 0, 0, 0, 0, 2);
        drive_frame(2, 8, 8'h60, -1);
        end_test("short_frame", 1, 1'b0, 1'b0, 1'b1);

        // Reset during line 1, then a clean capture
        snap();
        expect_frame(3, 8, 8'h70, 0, 0, 0, 0, 1);
        drive_frame(3, 8, 8'h70, 1);
        end_test("reset_frame", 0, 1'b0, 1'b0, 1'b0);
        snap();
        expect_frame(3, 8, 8'h80, 0, 0, 0, 0, 3);
        drive_frame(3, 8, 8'h80, -1);
        end_test("after_reset", 1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
